// File: rtl/traffic_pkg.sv
// Shared types, default timing and the round-robin phase picker for the
// N-phase traffic controller.
package traffic_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    ALLRED = 3'd3,
    FLASH  = 3'd4
  } state_t;

  // Default geometry and durations (clk cycles).
  localparam int DEF_NUM_PHASE = 2;
  localparam int DEF_TMR_W     = 8;
  localparam int DEF_GREEN_T   = 20;
  localparam int DEF_YELLOW_T  = 4;
  localparam int DEF_ALLRED_T  = 2;
  localparam int DEF_FLASH_T   = 8;

  // The picker works on a fixed-size demand vector; NUM_PHASE must not exceed MAX_PHASE.
  localparam int MAX_PW    = 5;
  localparam int MAX_PHASE = 1 << MAX_PW;

  // First demanded phase after cur (cur+1, cur+2, ... wrapping at n-1, cur itself
  // last). With no demand at all the result is simply cur+1 modulo n. Wrap is an
  // explicit compare so non-power-of-two phase counts behave correctly.
  function automatic logic [MAX_PW-1:0] next_phase(
    input logic [MAX_PW-1:0]    cur,
    input logic [MAX_PHASE-1:0] req,
    input int                   n
  );
    logic [MAX_PW-1:0] last;
    logic [MAX_PW-1:0] idx;
    logic [MAX_PW-1:0] res;
    logic              found;
    last  = MAX_PW'(n - 1);
    res   = (cur == last) ? '0 : cur + 1'b1;
    idx   = cur;
    found = 1'b0;
    for (int k = 0; k < MAX_PHASE; k++) begin
      if (k < n) begin
        idx = (idx == last) ? '0 : idx + 1'b1;
        if (!found && req[idx]) begin
          res   = idx;
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Run/flash/demand inputs and lamp/status outputs of the traffic controller.
interface traffic_phase_ctrl_if #(
  parameter int NUM_PHASE = 2
);
  localparam int PW = (NUM_PHASE > 1) ? $clog2(NUM_PHASE) : 1;

  logic                 start;
  logic                 flash;
  logic [NUM_PHASE-1:0] req;
  logic [NUM_PHASE-1:0] r;
  logic [NUM_PHASE-1:0] g;
  logic [NUM_PHASE-1:0] y;
  logic [PW-1:0]        phase;
  logic                 busy;

  // Supervisor / detector side.
  modport master (
    output start, flash, req,
    input  r, g, y, phase, busy
  );

  // Controller side.
  modport slave (
    input  start, flash, req,
    output r, g, y, phase, busy
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable saturating down counter with a registered "count is zero" flag.
// Load wins over enable; the flag always tracks the stored count.
module phase_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             enable,
  output logic             zero
);
  logic [TMR_W-1:0] count_reg;
  logic             zero_reg;

  // Load, or count down and stop at zero, keeping the zero flag in step.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      zero_reg  <= 1'b1;
    end else if (load) begin
      count_reg <= load_val;
      zero_reg  <= (load_val == '0);
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
      zero_reg  <= (count_reg == TMR_W'(1));
    end
  end

  assign zero = zero_reg;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase traffic-light controller: round-robin green/yellow/all-red
// sequencing with rest-in-green and a flashing-yellow fault mode.
// Lamps, phase and busy are all registered and change on the same edge
// as the state.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASE = DEF_NUM_PHASE,
  parameter int TMR_W     = DEF_TMR_W,
  parameter int GREEN_T   = DEF_GREEN_T,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int FLASH_T   = DEF_FLASH_T
) (
  input  logic               clk,
  input  logic               reset,
  traffic_phase_ctrl_if.slave bus
);
  localparam int PW = (NUM_PHASE > 1) ? $clog2(NUM_PHASE) : 1;

  // Timer loads are DUR-1 so each state lasts exactly DUR cycles.
  localparam logic [TMR_W-1:0] GREEN_LD  = TMR_W'(GREEN_T - 1);
  localparam logic [TMR_W-1:0] YELLOW_LD = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] ALLRED_LD = TMR_W'(ALLRED_T - 1);
  localparam logic [TMR_W-1:0] FLASH_LD  = TMR_W'(FLASH_T - 1);

  state_t               state_reg, state_next;
  logic [PW-1:0]        phase_reg, phase_next, phase_rr;
  logic                 blink_reg, blink_next;
  logic                 busy_reg, busy_next;
  logic [NUM_PHASE-1:0] r_reg, g_reg, y_reg;
  logic [NUM_PHASE-1:0] r_next, g_next, y_next;
  logic [NUM_PHASE-1:0] own_oh, own_next_oh;

  logic                 tmr_load, tmr_zero;
  logic [TMR_W-1:0]     tmr_val;
  logic                 blk_load, blk_zero, blk_en;
  logic [TMR_W-1:0]     blk_val;

  // Phase-duration timer.
  phase_timer #(.TMR_W(TMR_W)) u_state_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .enable   (1'b1),
    .zero     (tmr_zero)
  );

  // Blink half-period divider, only running while flashing.
  phase_timer #(.TMR_W(TMR_W)) u_blink_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (blk_load),
    .load_val (blk_val),
    .enable   (blk_en),
    .zero     (blk_zero)
  );

  assign blk_en   = (state_reg == FLASH);
  assign phase_rr = PW'(next_phase(MAX_PW'(phase_reg), MAX_PHASE'(bus.req), NUM_PHASE));

  // Per-phase decode of the current owner and of the next lamp pattern.
  for (genvar gi = 0; gi < NUM_PHASE; gi++) begin : g_lamp
    assign own_oh[gi]      = (phase_reg == PW'(gi));
    assign own_next_oh[gi] = (phase_next == PW'(gi));
    assign g_next[gi]      = (state_next == GREEN) && own_next_oh[gi];
    assign y_next[gi]      = ((state_next == YELLOW) && own_next_oh[gi]) ||
                             ((state_next == FLASH) && blink_next);
    assign r_next[gi]      = (state_next != FLASH) && !g_next[gi] && !y_next[gi];
  end

  assign busy_next = (state_next != IDLE);

  // Next-state, next-phase and timer-load decisions; flash overrides everything.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    blink_next = blink_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    blk_load   = 1'b0;
    blk_val    = FLASH_LD;
    if (bus.flash) begin
      state_next = FLASH;
      if (state_reg != FLASH) begin
        blink_next = 1'b1;
        blk_load   = 1'b1;
      end else if (blk_zero) begin
        blink_next = !blink_reg;
        blk_load   = 1'b1;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_next = GREEN;
            tmr_load   = 1'b1;
            tmr_val    = GREEN_LD;
          end
        end
        GREEN: begin
          // Rest in green until another phase asks for service.
          if (tmr_zero && ((bus.req & ~own_oh) != '0)) begin
            state_next = YELLOW;
            tmr_load   = 1'b1;
            tmr_val    = YELLOW_LD;
          end
        end
        YELLOW: begin
          if (tmr_zero) begin
            state_next = ALLRED;
            tmr_load   = 1'b1;
            tmr_val    = ALLRED_LD;
          end
        end
        ALLRED: begin
          // Run enable is only looked at here, so a cycle always completes.
          if (tmr_zero) begin
            if (!bus.start) begin
              state_next = IDLE;
            end else begin
              state_next = GREEN;
              phase_next = phase_rr;
              tmr_load   = 1'b1;
              tmr_val    = GREEN_LD;
            end
          end
        end
        FLASH: begin
          // Leaving flash always restarts through a full clearance interval.
          state_next = ALLRED;
          tmr_load   = 1'b1;
          tmr_val    = ALLRED_LD;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      blink_reg <= 1'b0;
      busy_reg  <= 1'b0;
      r_reg     <= '1;
      g_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      blink_reg <= blink_next;
      busy_reg  <= busy_next;
      r_reg     <= r_next;
      g_reg     <= g_next;
      y_reg     <= y_next;
    end
  end

  assign bus.r     = r_reg;
  assign bus.g     = g_reg;
  assign bus.y     = y_reg;
  assign bus.phase = phase_reg;
  assign bus.busy  = busy_reg;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed cycle-table test of the 3-phase traffic controller followed by a
// random soak that checks the lamp safety invariants every cycle.
module tb_traffic_phase_ctrl;
  localparam int NP = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  traffic_phase_ctrl_if #(.NUM_PHASE(NP)) bus ();

  traffic_phase_ctrl #(
    .NUM_PHASE (NP),
    .TMR_W     (8),
    .GREEN_T   (5),
    .YELLOW_T  (2),
    .ALLRED_T  (1),
    .FLASH_T   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs held for n cycles, expected outputs after each of those edges.
  typedef struct {
    logic       rst;
    logic       st;
    logic       fl;
    logic [2:0] req;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] y;
    logic [1:0] ph;
    logic       busy;
    int         n;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic fl,
                              input logic [2:0] req, input logic [2:0] r,
                              input logic [2:0] g, input logic [2:0] y,
                              input logic [1:0] ph, input logic busy, input int n);
    vec_t v;
    v.rst = rst; v.st = st; v.fl = fl; v.req = req;
    v.r = r; v.g = g; v.y = y; v.ph = ph; v.busy = busy; v.n = n;
    return v;
  endfunction

  initial begin
    int   last_lit;
    int   cur;
    logic fl_soak;

    checks = 0;
    errors = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.flash = 1'b0;
    bus.req   = '0;

    //                 rst  st   fl   req     r       g       y       ph     busy n
    // reset and idle
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'b000,3'b111,3'b000,3'b000,2'd0,1'b0,4));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'b000,3'b111,3'b000,3'b000,2'd0,1'b0,2));
    // phase 0 -> phase 1 with req=010
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b010,3'b110,3'b001,3'b000,2'd0,1'b1,5));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b010,3'b110,3'b000,3'b001,2'd0,1'b1,2));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b010,3'b111,3'b000,3'b000,2'd0,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b010,3'b101,3'b010,3'b000,2'd1,1'b1,3));
    // reset during green
    tbl.push_back(mk(1'b1,1'b1,1'b0,3'b010,3'b111,3'b000,3'b000,2'd0,1'b0,1));
    // rest in green, then req=100 skips phase 1
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b000,3'b110,3'b001,3'b000,2'd0,1'b1,20));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b100,3'b110,3'b000,3'b001,2'd0,1'b1,2));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b100,3'b111,3'b000,3'b000,2'd0,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b100,3'b011,3'b100,3'b000,2'd2,1'b1,5));
    // start dropped in green of phase 2: cycle completes, then IDLE keeping phase
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'b000,3'b011,3'b100,3'b000,2'd2,1'b1,2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'b001,3'b011,3'b000,3'b100,2'd2,1'b1,2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'b001,3'b111,3'b000,3'b000,2'd2,1'b1,1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'b001,3'b111,3'b000,3'b000,2'd2,1'b0,2));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b000,3'b011,3'b100,3'b000,2'd2,1'b1,5));
    // flash during yellow, blink 3 on / 3 off, drop -> all-red -> phase 1
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b001,3'b011,3'b000,3'b100,2'd2,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b1,3'b001,3'b000,3'b000,3'b111,2'd2,1'b1,3));
    tbl.push_back(mk(1'b0,1'b1,1'b1,3'b001,3'b000,3'b000,3'b000,2'd2,1'b1,3));
    tbl.push_back(mk(1'b0,1'b1,1'b1,3'b001,3'b000,3'b000,3'b111,2'd2,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b010,3'b111,3'b000,3'b000,2'd2,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b010,3'b101,3'b010,3'b000,2'd1,1'b1,5));
    // no demand at all-red exit -> phase+1
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b100,3'b101,3'b000,3'b010,2'd1,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b000,3'b101,3'b000,3'b010,2'd1,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b000,3'b111,3'b000,3'b000,2'd1,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b000,3'b011,3'b100,3'b000,2'd2,1'b1,5));
    // no demand from phase 2 wraps to phase 0
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b001,3'b011,3'b000,3'b100,2'd2,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b000,3'b011,3'b000,3'b100,2'd2,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b000,3'b111,3'b000,3'b000,2'd2,1'b1,1));
    tbl.push_back(mk(1'b0,1'b1,1'b0,3'b000,3'b110,3'b001,3'b000,2'd0,1'b1,1));
    // flash from IDLE, then all-red and back to IDLE with start low
    tbl.push_back(mk(1'b1,1'b0,1'b0,3'b000,3'b111,3'b000,3'b000,2'd0,1'b0,1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,3'b000,3'b000,3'b000,3'b111,2'd0,1'b1,1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'b000,3'b111,3'b000,3'b000,2'd0,1'b1,1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'b000,3'b111,3'b000,3'b000,2'd0,1'b0,2));

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        reset     = tbl[i].rst;
        bus.start = tbl[i].st;
        bus.flash = tbl[i].fl;
        bus.req   = tbl[i].req;
        @(posedge clk);
        #1;
        checks++;
        if (bus.r !== tbl[i].r || bus.g !== tbl[i].g || bus.y !== tbl[i].y ||
            bus.phase !== tbl[i].ph || bus.busy !== tbl[i].busy) begin
          errors++;
          $display("FAIL row %0d cycle %0d: got r=%b g=%b y=%b phase=%0d busy=%b, want r=%b g=%b y=%b phase=%0d busy=%b",
                   i, c, bus.r, bus.g, bus.y, bus.phase, bus.busy,
                   tbl[i].r, tbl[i].g, tbl[i].y, tbl[i].ph, tbl[i].busy);
        end
      end
      $display("row %0d: req=%b start=%b flash=%b -> r=%b g=%b y=%b phase=%0d busy=%b",
               i, tbl[i].req, tbl[i].st, tbl[i].fl, bus.r, bus.g, bus.y, bus.phase, bus.busy);
    end

    // Random soak: safety invariants checked every cycle.
    last_lit = -1;
    fl_soak  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      bus.start = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) fl_soak = !fl_soak;
      bus.flash = fl_soak;
      bus.req   = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      checks++;
      if ($countones(bus.g) > 1) begin
        errors++;
        $display("FAIL soak_one_green cycle %0d: got g=%b, want at most one bit set", c, bus.g);
      end
      checks++;
      if (bus.phase > 2'd2) begin
        errors++;
        $display("FAIL soak_phase_range cycle %0d: got phase=%0d, want <= 2", c, bus.phase);
      end
      if (bus.r == 3'b000) begin
        // Flashing: only yellows may be lit, all equal.
        checks++;
        if (bus.g != 3'b000 || (bus.y != 3'b000 && bus.y != 3'b111)) begin
          errors++;
          $display("FAIL soak_flash_lamps cycle %0d: got g=%b y=%b, want g=000 y=000/111", c, bus.g, bus.y);
        end
        last_lit = -2;
      end else begin
        checks++;
        if ((bus.r ^ bus.g ^ bus.y) != 3'b111 || (bus.r & bus.g) != 3'b000 ||
            (bus.r & bus.y) != 3'b000 || (bus.g & bus.y) != 3'b000) begin
          errors++;
          $display("FAIL soak_one_lamp cycle %0d: got r=%b g=%b y=%b, want exactly one lamp per phase",
                   c, bus.r, bus.g, bus.y);
        end
        if (bus.r == 3'b111) begin
          last_lit = -1;
        end else begin
          cur = bus.g[0] || bus.y[0] ? 0 : (bus.g[1] || bus.y[1] ? 1 : 2);
          if (bus.g != 3'b000) begin
            checks++;
            if (last_lit != -1 && last_lit != cur) begin
              errors++;
              $display("FAIL soak_clearance cycle %0d: got green on %0d after %0d, want all-red between",
                       c, cur, last_lit);
            end
            checks++;
            if (int'(bus.phase) != cur) begin
              errors++;
              $display("FAIL soak_green_phase cycle %0d: got phase=%0d, want %0d", c, bus.phase, cur);
            end
          end
          last_lit = cur;
        end
      end
    end
    $display("soak: 3000 cycles done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
